// File: rtl/fifo_sram_ctrl.sv
// fifo_sram_ctrl
//   Sequencer that turns an external two-port SRAM (one write port, one read
//   port, 1-cycle read latency) into a valid/ready FIFO. It owns the pointers
//   and the occupancy count, drives both SRAM ports, and prefetches read data
//   into a 2-entry output buffer so the consumer side can pop one entry per
//   cycle. Total capacity is SIZE (SRAM) + 2 (output buffer).
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   flush_i                   synchronous flush, empties the FIFO at the next edge
//   push_val_i/push_rdy_o     producer handshake, push_dat_i carries the entry
//   pop_val_o/pop_rdy_i       consumer handshake, pop_dat_o is the buffer head
//   wr_val_o/wr_adr_o/wr_dat_o  SRAM write port
//   rd_val_o/rd_adr_o         SRAM read request
//   rd_dat_i                  SRAM read data, valid the cycle after rd_val_o
//   lvl_o                     total occupancy (only with FIFO_SRAM_CTRL_LEVEL_EN)
//
// Configuration
//   FIFO_SRAM_CTRL_LEVEL_EN   when defined, adds the registered occupancy
//                             output lvl_o; otherwise the port is absent.

module fifo_sram_ctrl #(
    parameter int  SIZE    = 64,
    parameter int  DATA_WD = 32,
    localparam int SIZE_WD = $clog2(SIZE)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               flush_i,
    input  logic               push_val_i,
    output logic               push_rdy_o,
    input  logic [DATA_WD-1:0] push_dat_i,
    output logic               pop_val_o,
    input  logic               pop_rdy_i,
    output logic [DATA_WD-1:0] pop_dat_o,
    output logic               wr_val_o,
    output logic [SIZE_WD-1:0] wr_adr_o,
    output logic [DATA_WD-1:0] wr_dat_o,
    output logic               rd_val_o,
    output logic [SIZE_WD-1:0] rd_adr_o,
    input  logic [DATA_WD-1:0] rd_dat_i
`ifdef FIFO_SRAM_CTRL_LEVEL_EN
    ,
    output logic [SIZE_WD+1:0] lvl_o
`endif
);

    localparam logic [SIZE_WD:0] FULL_CNT = (SIZE_WD+1)'(SIZE);

    logic [SIZE_WD-1:0] wr_ptr;
    logic [SIZE_WD-1:0] rd_ptr;
    logic [SIZE_WD:0]   sram_cnt;
    logic               inflight;
    logic [1:0]         buf_cnt;
    logic [DATA_WD-1:0] buf_mem [2];
    logic               buf_head;
    logic               buf_tail;
    logic               push_fire;
    logic               pop_fire;
    logic [2:0]         buf_occ;

    // Handshakes. push_rdy_o looks only at the registered SRAM count, so a
    // read issued this cycle never frees a slot for a push in the same cycle.
    assign push_rdy_o = (sram_cnt != FULL_CNT) & ~flush_i;
    assign pop_val_o  = (buf_cnt != 2'd0);
    assign pop_dat_o  = buf_mem[buf_head];
    assign push_fire  = push_val_i & push_rdy_o;
    assign pop_fire   = pop_val_o & pop_rdy_i;

    // Buffer slots already spoken for after this cycle's pop: the entries held
    // plus the one returning from the SRAM. A new read is only issued when at
    // least one slot will be free when its data lands, so buf_cnt never
    // exceeds 2. pop_fire implies buf_cnt >= 1, so this cannot underflow.
    assign buf_occ = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop_fire};

    // sram_cnt counts committed writes only, so a read can never target the
    // address being written in the same cycle.
    assign rd_val_o = (sram_cnt != '0) & ~flush_i & (buf_occ <= 3'd1);

    assign wr_val_o = push_fire;
    assign wr_adr_o = wr_ptr;
    assign wr_dat_o = push_dat_i;
    assign rd_adr_o = rd_ptr;

    // Pointer, count and buffer bookkeeping. A flush drops everything,
    // including data of a read still in flight; buffer contents themselves
    // are left alone since buf_cnt=0 already hides them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            sram_cnt   <= '0;
            inflight   <= 1'b0;
            buf_cnt    <= 2'd0;
            buf_head   <= 1'b0;
            buf_tail   <= 1'b0;
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
        end else if (flush_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sram_cnt <= '0;
            inflight <= 1'b0;
            buf_cnt  <= 2'd0;
            buf_head <= 1'b0;
            buf_tail <= 1'b0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_val_o) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            sram_cnt <= sram_cnt + (SIZE_WD+1)'(push_fire) - (SIZE_WD+1)'(rd_val_o);
            inflight <= rd_val_o;
            if (inflight) begin
                buf_mem[buf_tail] <= rd_dat_i;
                buf_tail          <= ~buf_tail;
            end
            if (pop_fire) begin
                buf_head <= ~buf_head;
            end
            buf_cnt <= buf_cnt + 2'(inflight) - 2'(pop_fire);
        end
    end

`ifdef FIFO_SRAM_CTRL_LEVEL_EN
    logic [SIZE_WD+1:0] lvl_q;

    // sram_cnt + inflight + buf_cnt only changes by push_fire - pop_fire, so
    // tracking that delta keeps lvl_o registered without a wide adder.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lvl_q <= '0;
        end else if (flush_i) begin
            lvl_q <= '0;
        end else begin
            lvl_q <= lvl_q + (SIZE_WD+2)'(push_fire) - (SIZE_WD+2)'(pop_fire);
        end
    end

    assign lvl_o = lvl_q;
`endif

endmodule

// File: tb/tb_fifo_sram_ctrl.sv
// tb_fifo_sram_ctrl
//   Bench for fifo_sram_ctrl with a behavioural two-port SRAM (1-cycle read
//   latency). A cycle-by-cycle vector table covers reset, single-entry latency,
//   buffer back-pressure and flush with a read in flight; hand-written
//   sequences cover fill to capacity, streaming throughput with pointer wrap,
//   random handshakes against a scoreboard, and async reset mid-stream.

module tb_fifo_sram_ctrl;

    localparam int SIZE    = 64;
    localparam int DATA_WD = 32;
    localparam int SIZE_WD = 6;

    logic               clk;
    logic               rstn;
    logic               flush;
    logic               push_val;
    logic               push_rdy;
    logic [DATA_WD-1:0] push_dat;
    logic               pop_val;
    logic               pop_rdy;
    logic [DATA_WD-1:0] pop_dat;
    logic               wr_val;
    logic [SIZE_WD-1:0] wr_adr;
    logic [DATA_WD-1:0] wr_dat;
    logic               rd_val;
    logic [SIZE_WD-1:0] rd_adr;
    logic [DATA_WD-1:0] rd_dat;
`ifdef FIFO_SRAM_CTRL_LEVEL_EN
    logic [SIZE_WD+1:0] lvl;
`endif

    int tests_run;
    int tests_failed;

    fifo_sram_ctrl #(.SIZE(SIZE), .DATA_WD(DATA_WD)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush_i    (flush),
        .push_val_i (push_val),
        .push_rdy_o (push_rdy),
        .push_dat_i (push_dat),
        .pop_val_o  (pop_val),
        .pop_rdy_i  (pop_rdy),
        .pop_dat_o  (pop_dat),
        .wr_val_o   (wr_val),
        .wr_adr_o   (wr_adr),
        .wr_dat_o   (wr_dat),
        .rd_val_o   (rd_val),
        .rd_adr_o   (rd_adr),
        .rd_dat_i   (rd_dat)
`ifdef FIFO_SRAM_CTRL_LEVEL_EN
        ,
        .lvl_o      (lvl)
`endif
    );

    // Behavioural SRAM owned by the parent: synchronous write, registered read.
    logic [DATA_WD-1:0] mem [SIZE];
    always @(posedge clk) begin
        if (wr_val) mem[wr_adr] <= wr_dat;
        if (rd_val) rd_dat <= mem[rd_adr];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic        flush;
        logic        push_val;
        logic [31:0] push_dat;
        logic        pop_rdy;
        logic        e_push_rdy;
        logic        e_pop_val;
        logic [31:0] e_pop_dat;
        logic        e_wr_val;
        logic [5:0]  e_wr_adr;
        logic        e_rd_val;
        logic [5:0]  e_rd_adr;
        logic [7:0]  e_lvl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fl, input logic pv, input logic [31:0] pd,
                                input logic pr, input logic eprdy, input logic epv,
                                input logic [31:0] epd, input logic ewv, input logic [5:0] ewa,
                                input logic erv, input logic [5:0] era, input logic [7:0] elvl);
        vec_t v;
        v.flush = fl;        v.push_val = pv;   v.push_dat = pd;  v.pop_rdy = pr;
        v.e_push_rdy = eprdy; v.e_pop_val = epv; v.e_pop_dat = epd;
        v.e_wr_val = ewv;    v.e_wr_adr = ewa;  v.e_rd_val = erv; v.e_rd_adr = era;
        v.e_lvl = elvl;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        flush    = v.flush;
        push_val = v.push_val;
        push_dat = v.push_dat;
        pop_rdy  = v.pop_rdy;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        checkVal({tag, "_push_rdy"}, push_rdy, v.e_push_rdy);
        checkVal({tag, "_pop_val"},  pop_val,  v.e_pop_val);
        checkVal({tag, "_wr_val"},   wr_val,   v.e_wr_val);
        checkVal({tag, "_rd_val"},   rd_val,   v.e_rd_val);
        if (v.e_pop_val) checkVal({tag, "_pop_dat"}, pop_dat, v.e_pop_dat);
        if (v.e_wr_val)  checkVal({tag, "_wr_adr"},  wr_adr,  v.e_wr_adr);
        if (v.e_rd_val)  checkVal({tag, "_rd_adr"},  rd_adr,  v.e_rd_adr);
`ifdef FIFO_SRAM_CTRL_LEVEL_EN
        checkVal({tag, "_lvl"}, lvl, v.e_lvl);
`endif
    endtask

    // Scoreboard state shared by the hand-written sequences.
    logic [31:0] sb[$];
    int          cyc;
    logic        last_pop_fire;

    task automatic doReset();
        rstn     = 1'b0;
        flush    = 1'b0;
        push_val = 1'b0;
        push_dat = '0;
        pop_rdy  = 1'b0;
        @(negedge clk);
        #1;
        checkVal("reset_push_rdy", push_rdy, 1);
        checkVal("reset_pop_val",  pop_val,  0);
        checkVal("reset_pop_dat",  pop_dat,  0);
        checkVal("reset_rd_val",   rd_val,   0);
`ifdef FIFO_SRAM_CTRL_LEVEL_EN
        checkVal("reset_lvl", lvl, 0);
`endif
        @(negedge clk);
        rstn = 1'b1;
        sb.delete();
    endtask

    // One cycle of handshake traffic checked against the scoreboard.
    task automatic runCycle(input logic pv, input logic [31:0] pd, input logic pr);
        @(negedge clk);
        flush    = 1'b0;
        push_val = pv;
        push_dat = pd;
        pop_rdy  = pr;
        #1;
        cyc++;
        if (rd_val && wr_val) checkVal("raw_adr_differs", 32'(rd_adr != wr_adr), 1);
        if (wr_val) checkVal("wr_dat_passthru", wr_dat, pd);
        last_pop_fire = pop_val & pop_rdy;
        if (last_pop_fire) begin
            if (sb.size() == 0) begin
                checkVal("pop_unexpected", 1, 0);
            end else begin
                checkVal("pop_data", pop_dat, sb[0]);
                void'(sb.pop_front());
            end
        end
        if (pv && push_rdy) sb.push_back(pd);
    endtask

    initial begin
        int          accepted;
        int          popped;
        int          first_pop;
        int          last_pop;
        logic [31:0] next_dat;

        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;

        //           fl pv  pd            pr prdy pv  pdat          wv wa    rv ra    lvl
        vecs.push_back(mk(0, 1, 32'hA5,  1, 1, 0, 32'h0,  1, 6'd0, 0, 6'd0, 8'd0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 0, 32'h0,  0, 6'd0, 1, 6'd0, 8'd1));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 0, 32'h0,  0, 6'd0, 0, 6'd0, 8'd1));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 1, 32'hA5, 0, 6'd0, 0, 6'd0, 8'd1));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 0, 32'h0,  0, 6'd0, 0, 6'd0, 8'd0));
        vecs.push_back(mk(0, 1, 32'hB1,  0, 1, 0, 32'h0,  1, 6'd1, 0, 6'd0, 8'd0));
        vecs.push_back(mk(0, 1, 32'hB2,  0, 1, 0, 32'h0,  1, 6'd2, 1, 6'd1, 8'd1));
        vecs.push_back(mk(0, 0, 32'h0,   0, 1, 0, 32'h0,  0, 6'd0, 1, 6'd2, 8'd2));
        vecs.push_back(mk(0, 0, 32'h0,   0, 1, 1, 32'hB1, 0, 6'd0, 0, 6'd0, 8'd2));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 1, 32'hB1, 0, 6'd0, 0, 6'd0, 8'd2));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 1, 32'hB2, 0, 6'd0, 0, 6'd0, 8'd1));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 0, 32'h0,  0, 6'd0, 0, 6'd0, 8'd0));
        vecs.push_back(mk(0, 1, 32'hC1,  0, 1, 0, 32'h0,  1, 6'd3, 0, 6'd0, 8'd0));
        vecs.push_back(mk(0, 1, 32'hC2,  0, 1, 0, 32'h0,  1, 6'd4, 1, 6'd3, 8'd1));
        vecs.push_back(mk(1, 1, 32'hC3,  0, 0, 0, 32'h0,  0, 6'd0, 0, 6'd0, 8'd2));
        vecs.push_back(mk(0, 1, 32'h3C,  1, 1, 0, 32'h0,  1, 6'd0, 0, 6'd0, 8'd0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 0, 32'h0,  0, 6'd0, 1, 6'd0, 8'd1));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 0, 32'h0,  0, 6'd0, 0, 6'd0, 8'd1));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 1, 32'h3C, 0, 6'd0, 0, 6'd0, 8'd1));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 0, 32'h0,  0, 6'd0, 0, 6'd0, 8'd0));

        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput(vecs[i], i);
        end

        // Fill to capacity with the consumer stalled, then drain in order.
        doReset();
        accepted = 0;
        for (int i = 0; i < 80; i++) begin
            runCycle(1'b1, 32'(accepted), 1'b0);
            if (push_rdy) accepted++;
        end
        checkVal("fill_accepted", accepted, SIZE + 2);
        checkVal("fill_push_rdy", push_rdy, 0);
        checkVal("fill_no_write", wr_val, 0);
`ifdef FIFO_SRAM_CTRL_LEVEL_EN
        checkVal("fill_lvl", lvl, SIZE + 2);
`endif
        for (int i = 0; i < 150 && sb.size() != 0; i++) begin
            runCycle(1'b0, 32'h0, 1'b1);
        end
        checkVal("fill_drained", sb.size(), 0);

        // Streaming push+pop: one pop per cycle once the pipe has filled.
        doReset();
        accepted  = 0;
        popped    = 0;
        first_pop = -1;
        last_pop  = -1;
        for (int i = 0; i < 400 && popped < 200; i++) begin
            runCycle(accepted < 200, 32'h1000 + 32'(accepted), 1'b1);
            if (push_val && push_rdy) accepted++;
            if (last_pop_fire) begin
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                popped++;
            end
        end
        checkVal("stream_popped", popped, 200);
        checkVal("stream_throughput", last_pop - first_pop, 199);

        // Random handshakes against the scoreboard.
        doReset();
        accepted = 0;
        popped   = 0;
        for (int i = 0; i < 20000 && popped < 3000; i++) begin
            next_dat = $urandom;
            runCycle((accepted < 3000) && ($urandom_range(0, 1) == 1), next_dat,
                     $urandom_range(0, 1) == 1);
            if (push_val && push_rdy) accepted++;
            if (last_pop_fire) popped++;
        end
        checkVal("random_popped", popped, 3000);

        // Async reset while 20 entries are held.
        doReset();
        for (int i = 0; i < 20; i++) begin
            runCycle(1'b1, 32'h2000 + 32'(i), 1'b0);
        end
        @(negedge clk);
        push_val = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        checkVal("async_rst_pop_val",  pop_val,  0);
        checkVal("async_rst_push_rdy", push_rdy, 1);
        checkVal("async_rst_rd_val",   rd_val,   0);
`ifdef FIFO_SRAM_CTRL_LEVEL_EN
        checkVal("async_rst_lvl", lvl, 0);
`endif
        sb.delete();
        @(negedge clk);
        rstn = 1'b1;
        runCycle(1'b1, 32'h77, 1'b1);
        checkVal("post_rst_wr_adr", wr_adr, 0);
        popped = 0;
        for (int i = 0; i < 10 && popped == 0; i++) begin
            runCycle(1'b0, 32'h0, 1'b1);
            if (last_pop_fire) popped++;
        end
        checkVal("post_rst_popped", popped, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
